// File: rtl/regfile_wb.sv
// picoMIPS register file with one-deep write-back register; R[0] is hard-wired zero.
// Optional operand forwarding from the pending write is enabled by defining REGFILE_FORWARD_EN.
module regfile_wb #(
    parameter int n      = 8,
    parameter int addr_w = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [addr_w-1:0] wa,
    input  logic [n-1:0]      wd,
    input  logic [addr_w-1:0] ra_a,
    input  logic [addr_w-1:0] ra_b,
    output logic [n-1:0]      rd_a,
    output logic [n-1:0]      rd_b,
    output logic [n-1:0]      outport,
    output logic              wb_pending
);

    localparam int unsigned depth = 2 ** addr_w;

    logic [n-1:0]      r [depth];
    logic              p_valid;
    logic [addr_w-1:0] p_addr;
    logic [n-1:0]      p_data;

    // Commit of the old pending write and capture of the new one share an edge,
    // so a same-address pair lands in order with nothing lost.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r       <= '{default: '0};
            p_valid <= 1'b0;
            p_addr  <= '0;
            p_data  <= '0;
        end else begin
            if (p_valid && (p_addr != '0))
                r[p_addr] <= p_data;
            p_valid <= we && (wa != '0);
            if (we && (wa != '0)) begin
                p_addr <= wa;
                p_data <= wd;
            end
        end
    end

    always_comb begin
        rd_a = '0;
        if (ra_a != '0) begin
            rd_a = r[ra_a];
`ifdef REGFILE_FORWARD_EN
            if (p_valid && (ra_a == p_addr))
                rd_a = p_data;
`endif
        end
    end

    always_comb begin
        rd_b = '0;
        if (ra_b != '0) begin
            rd_b = r[ra_b];
`ifdef REGFILE_FORWARD_EN
            if (p_valid && (ra_b == p_addr))
                rd_b = p_data;
`endif
        end
    end

    // The output port shows committed state only, never the pending value.
    assign outport    = r[{addr_w{1'b1}}];
    assign wb_pending = p_valid;

endmodule
